// File: rtl/emif_calbus_pkg.sv
// EMIF calibration bus responder: shared constants and types.
// Address map, control bit positions and FSM state encoding.
package emif_calbus_pkg;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 32;
  localparam int TBL_W     = 4096;
  localparam int TBL_WORDS = 128;

  localparam logic [ADDR_W-1:0] TBL_BASE     = 20'h00000;
  localparam logic [ADDR_W-1:0] CTRL_ADDR    = 20'h00100;
  localparam logic [ADDR_W-1:0] STATUS_ADDR  = 20'h00101;
  localparam logic [ADDR_W-1:0] SCRATCH_ADDR = 20'h00102;
  localparam logic [ADDR_W-1:0] WRCNT_ADDR   = 20'h00103;

  localparam int CTRL_LOCK     = 0;
  localparam int CTRL_CAL_DONE = 1;
  localparam int CTRL_CAL_FAIL = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/emif_calbus_rd_pipe.sv
// Fixed-latency read return pipe for the calbus responder.
// Holds the last delivered word until the next one lands.
module emif_calbus_rd_pipe
  import emif_calbus_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata
);

  logic [LAT-1:0]    v;
  logic [DATA_W-1:0] d [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      rdata <= '0;
      for (int i = 0; i < int'(LAT); i++) d[i] <= '0;
    end else begin
      v[0] <= vld;
      d[0] <= data;
      for (int i = 1; i < int'(LAT); i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
      if (v[LAT-1]) rdata <= d[LAT-1];
    end
  end

endmodule

// File: rtl/emif_calbus_responder.sv
// Calbus target: parameter table, control/status window and
// fixed-latency read return.
module emif_calbus_responder
  import emif_calbus_pkg::*;
#(
  parameter int unsigned        RD_LATENCY    = 1,
  parameter logic [TBL_W-1:0]   PARAM_INIT    = '0,
  parameter logic [DATA_W-1:0]  DEFAULT_RDATA = 32'hDEAD_BEEF
) (
  input  logic              calbus_clk,
  input  logic              calbus_rst,
  input  logic              calbus_read,
  input  logic              calbus_write,
  input  logic [ADDR_W-1:0] calbus_address,
  input  logic [DATA_W-1:0] calbus_wdata,
  output logic [DATA_W-1:0] calbus_rdata,
  output logic [TBL_W-1:0]  calbus_seq_param_tbl,
  output logic              init_done,
  output logic              cal_done,
  output logic              cal_fail,
  output logic              tbl_locked,
  output logic              err_pulse
);

  state_t state, state_nxt;

  logic [6:0]        idx;
  logic [DATA_W-1:0] tbl [TBL_WORDS];
  logic [2:0]        ctrl;
  logic [DATA_W-1:0] scratch;
  logic [15:0]       wrcnt;

  logic              run;
  logic              hit_tbl, hit_ctrl, hit_stat;
  logic              hit_scr, hit_cnt;
  logic              wr_ok, wr_bad, rd_bad;
  logic [DATA_W-1:0] rd_val;

  assign run        = (state == ST_RUN);
  assign init_done  = run;
  assign tbl_locked = ctrl[CTRL_LOCK];
  assign cal_done   = ctrl[CTRL_CAL_DONE];
  assign cal_fail   = ctrl[CTRL_CAL_FAIL];

  assign hit_tbl  = calbus_address[ADDR_W-1:7]
                 == TBL_BASE[ADDR_W-1:7];
  assign hit_ctrl = calbus_address == CTRL_ADDR;
  assign hit_stat = calbus_address == STATUS_ADDR;
  assign hit_scr  = calbus_address == SCRATCH_ADDR;
  assign hit_cnt  = calbus_address == WRCNT_ADDR;

  always_comb begin
    wr_ok = 1'b0;
    if (calbus_write && run) begin
      unique case (1'b1)
        hit_tbl:  wr_ok = !ctrl[CTRL_LOCK];
        hit_ctrl: wr_ok = 1'b1;
        hit_scr:  wr_ok = 1'b1;
        default:  wr_ok = 1'b0;
      endcase
    end
  end

  assign wr_bad = calbus_write && !wr_ok;
  assign rd_bad = calbus_read && !run;

  // Read value sampled from pre-write state; zero while initialising.
  always_comb begin
    rd_val = '0;
    if (run) begin
      unique case (1'b1)
        hit_tbl:  rd_val = tbl[calbus_address[6:0]];
        hit_ctrl: rd_val = {29'b0, ctrl};
        hit_stat: rd_val = {29'b0, init_done,
                            ctrl[CTRL_LOCK],
                            ctrl[CTRL_CAL_DONE]};
        hit_scr:  rd_val = scratch;
        hit_cnt:  rd_val = {16'b0, wrcnt};
        default:  rd_val = DEFAULT_RDATA;
      endcase
    end
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_rst) state <= ST_INIT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (idx == 7'd127) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_rst) begin
      idx <= '0;
      for (int i = 0; i < TBL_WORDS; i++) tbl[i] <= '0;
    end else if (!run) begin
      tbl[idx] <= PARAM_INIT[{idx, 5'b0} +: DATA_W];
      idx      <= idx + 7'd1;
    end else if (wr_ok && hit_tbl) begin
      tbl[calbus_address[6:0]] <= calbus_wdata;
    end
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_rst) begin
      ctrl      <= '0;
      scratch   <= '0;
      wrcnt     <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= wr_bad | rd_bad;
      if (wr_ok && hit_ctrl) ctrl <= calbus_wdata[2:0];
      if (wr_ok && hit_scr) scratch <= calbus_wdata;
      if (wr_ok && wrcnt != 16'hFFFF) wrcnt <= wrcnt + 16'd1;
    end
  end

  for (genvar g = 0; g < TBL_WORDS; g++) begin : g_flat
    assign calbus_seq_param_tbl[32*g +: 32] = tbl[g];
  end

  emif_calbus_rd_pipe #(
    .LAT (RD_LATENCY)
  ) u_rd_pipe (
    .clk   (calbus_clk),
    .rst   (calbus_rst),
    .vld   (calbus_read),
    .data  (rd_val),
    .rdata (calbus_rdata)
  );

endmodule

// File: tb/tb_emif_calbus_responder.sv
// Directed scoreboard bench for the calbus responder,
// two instances at read latency 3 and 4 on shared stimulus.
module tb_emif_calbus_responder;

  localparam logic [4095:0] PINIT =
      (4096'h12345678 << 160)
    | (4096'hCAFE0001 << (32*127))
    | 4096'h0BADF00D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd  = 1'b0;
  logic          wr  = 1'b0;
  logic [19:0]   addr = '0;
  logic [31:0]   wdata = '0;

  logic [31:0]   rdata3, rdata4;
  logic [4095:0] tbl3, tbl4;
  logic          idone3, idone4, cdone3, cdone4;
  logic          cfail3, cfail4, lock3, lock4;
  logic          err3, err4;

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q3[$];
  exp_t        q4[$];
  logic [31:0] held3 = '0;
  logic [31:0] held4 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  emif_calbus_responder #(
    .RD_LATENCY (3),
    .PARAM_INIT (PINIT)
  ) u3 (
    .calbus_clk           (clk),
    .calbus_rst           (rst),
    .calbus_read          (rd),
    .calbus_write         (wr),
    .calbus_address       (addr),
    .calbus_wdata         (wdata),
    .calbus_rdata         (rdata3),
    .calbus_seq_param_tbl (tbl3),
    .init_done            (idone3),
    .cal_done             (cdone3),
    .cal_fail             (cfail3),
    .tbl_locked           (lock3),
    .err_pulse            (err3)
  );

  emif_calbus_responder #(
    .RD_LATENCY (4),
    .PARAM_INIT (PINIT)
  ) u4 (
    .calbus_clk           (clk),
    .calbus_rst           (rst),
    .calbus_read          (rd),
    .calbus_write         (wr),
    .calbus_address       (addr),
    .calbus_wdata         (wdata),
    .calbus_rdata         (rdata4),
    .calbus_seq_param_tbl (tbl4),
    .init_done            (idone4),
    .cal_done             (cdone4),
    .cal_fail             (cfail4),
    .tbl_locked           (lock4),
    .err_pulse            (err4)
  );

  // Read-return scoreboard: exact-cycle delivery, otherwise held value.
  always @(negedge clk) begin
    if (rst) begin
      q3.delete();
      q4.delete();
      held3 = '0;
      held4 = '0;
    end else begin
      n_cmp++;
      if (q3.size() != 0 && q3[0].due == edges) begin
        exp_t e;
        e = q3.pop_front();
        held3 = e.data;
        assert (rdata3 === e.data) else begin
          n_err++;
          $error("FAIL rd3 observed=%h expected=%h", rdata3, e.data);
        end
      end else begin
        assert (rdata3 === held3) else begin
          n_err++;
          $error("FAIL hold3 observed=%h expected=%h", rdata3, held3);
        end
      end
      n_cmp++;
      if (q4.size() != 0 && q4[0].due == edges) begin
        exp_t e;
        e = q4.pop_front();
        held4 = e.data;
        assert (rdata4 === e.data) else begin
          n_err++;
          $error("FAIL rd4 observed=%h expected=%h", rdata4, e.data);
        end
      end else begin
        assert (rdata4 === held4) else begin
          n_err++;
          $error("FAIL hold4 observed=%h expected=%h", rdata4, held4);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [19:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input bit push = 1'b1);
    @(negedge clk);
    rd = r;
    wr = w;
    addr = a;
    wdata = d;
    if (r && push) begin
      q3.push_back('{edges + 1 + 3, exp});
      q4.push_back('{edges + 1 + 4, exp});
    end
  endtask

  task automatic quiet();
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && (q3.size() != 0 || q4.size() != 0); i++)
      @(negedge clk);
    chk(tag, q3.size() + q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // 1: reset state and table initialisation
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata3, 0);
    chk("rst_tbl", {31'b0, |tbl3}, 0);
    chk("rst_flags", {27'b0, idone3, cdone3, cfail3, lock3, err3}, 0);
    rst = 1'b0;
    repeat (127) @(negedge clk);
    chk("init_127", {31'b0, idone3}, 0);
    @(negedge clk);
    chk("init_128", {31'b0, idone3}, 1);
    chk("init_128_u4", {31'b0, idone4}, 1);
    chk("tbl_w5", tbl3[191:160], 32'h12345678);
    chk("tbl_w127", tbl3[4095:4064], 32'hCAFE0001);
    chk("tbl_w0", tbl3[31:0], 32'h0BADF00D);

    // 2: table write then pipelined reads
    drive(0, 1, 20'h00007, 32'hA5A5A5A5, 0);
    chk("tbl_w7_pre", tbl3[255:224], 0);
    quiet();
    chk("tbl_w7_post", tbl3[255:224], 32'hA5A5A5A5);
    chk("err_ok_wr", {31'b0, err3}, 0);
    drive(1, 0, 20'h00007, 0, 32'hA5A5A5A5);
    drive(1, 0, 20'h00103, 0, 32'd1);
    drive(1, 0, 20'h00101, 0, 32'h4);
    quiet();
    drain("drain2");

    // 3: lock blocks table writes
    drive(0, 1, 20'h00100, 32'h1, 0);
    quiet();
    chk("lock_set", {31'b0, lock3}, 1);
    chk("ctrl_err", {31'b0, err3}, 0);
    drive(0, 1, 20'h00000, 32'hFFFFFFFF, 0);
    quiet();
    chk("lock_err", {31'b0, err3}, 1);
    chk("lock_tbl0", tbl3[31:0], 32'h0BADF00D);
    quiet();
    chk("err_oneshot", {31'b0, err3}, 0);
    drive(1, 0, 20'h00103, 0, 32'd2);
    drive(1, 0, 20'h00100, 0, 32'h1);
    drive(0, 1, 20'h00100, 32'hFFFFFFFE, 0);
    quiet();
    chk("cal_flags", {29'b0, cfail3, cdone3, lock3}, 3'b110);
    drive(1, 0, 20'h00100, 0, 32'h6);
    drive(1, 0, 20'h00101, 0, 32'h5);
    quiet();
    drain("drain3");

    // 4: simultaneous read and write sees the old value
    drive(1, 1, 20'h00102, 32'h55, 32'h0);
    drive(1, 0, 20'h00102, 0, 32'h55);
    quiet();
    drain("drain4");

    // 5: unmapped and read-only accesses
    drive(1, 0, 20'h00200, 0, 32'hDEADBEEF);
    drive(1, 0, 20'h00080, 0, 32'hDEADBEEF);
    quiet();
    drive(0, 1, 20'h00101, 32'hFFFFFFFF, 0);
    quiet();
    chk("ro_err", {31'b0, err3}, 1);
    drive(0, 1, 20'h00080, 32'h1, 0);
    quiet();
    chk("unmap_err", {31'b0, err3}, 1);
    drive(1, 0, 20'h00101, 0, 32'h5);
    drive(1, 0, 20'h00103, 0, 32'd4);
    drive(1, 0, 20'h00005, 0, 32'h12345678);
    drive(1, 0, 20'h0007F, 0, 32'hCAFE0001);
    quiet();
    drain("drain5");

    // 6: reset with a read in flight, then INIT restart
    drive(1, 0, 20'h00007, 0, 0, 1'b0);
    @(negedge clk);
    rd = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_rdata3", rdata3, 0);
    chk("rst2_rdata4", rdata4, 0);
    chk("rst2_flags", {29'b0, idone3, cdone3, lock3}, 0);
    chk("rst2_tbl", {31'b0, |tbl3}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reinit_w0", tbl3[31:0], 32'h0BADF00D);
    chk("reinit_w1", tbl3[63:32], 0);
    drive(1, 1, 20'h00000, 32'hFFFFFFFF, 32'h0);
    quiet();
    chk("init_wr_err", {31'b0, err3}, 1);
    chk("init_wr_drop", tbl3[31:0], 32'h0BADF00D);
    n = 3;
    while (!idone3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_len", n, 128);
    chk("reinit_err", {31'b0, err3}, 0);
    drive(1, 0, 20'h00103, 0, 32'd0);
    drive(1, 0, 20'h00007, 0, 32'd0);
    quiet();
    drain("drain6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/emif_calbus_responder.md
Name: emif_calbus_responder

Overview:
Responder (target) side of the EMIF calibration component bus. Accepts calbus read/write commands from the calibration initiator, decodes them into a 128-word sequencer parameter table plus a small control/status window, and returns read data with fixed configurable latency. Drives the 4096-bit flat parameter table back to the initiator. Also exports calibration done/fail flags to the memory-controller top level.

Parameters:
RD_LATENCY, 1, cycles from calbus_read sampled to calbus_rdata valid; legal range 1..4.
PARAM_INIT, 4096'h0, power-on parameter table contents; word i is bits [32*i+31:32*i].
DEFAULT_RDATA, 32'hDEAD_BEEF, read data returned for unmapped addresses.

Ports:
calbus_clk  in  1  calibration bus clock; all logic is on this clock.
calbus_rst  in  1  synchronous, active-high reset.
calbus_read  in  1  read command, one-cycle strobe.
calbus_write  in  1  write command, one-cycle strobe.
calbus_address  in  20  word address.
calbus_wdata  in  32  write data.
calbus_rdata  out  32  read data.
calbus_seq_param_tbl  out  4096  flat parameter table; word i at [32*i+31:32*i].
init_done  out  1  table initialisation complete.
cal_done  out  1  CTRL[1].
cal_fail  out  1  CTRL[2].
tbl_locked  out  1  CTRL[0]; parameter-table writes are blocked while set.
err_pulse  out  1  one-cycle pulse for each rejected or illegal access.

Behaviour:
- Reset values (all outputs): calbus_rdata=0, calbus_seq_param_tbl=0, init_done=0, cal_done=0, cal_fail=0, tbl_locked=0, err_pulse=0.
- Reset values (internal): write counter=0, SCRATCH=0, FSM state=INIT, init index=0.
- FSM states:
  - INIT: copies PARAM_INIT word[idx] into table word[idx], one word per cycle, idx 0..127 (128 cycles).
  - INIT to RUN: after word 127 is written; init_done rises in the same cycle RUN is entered.
  - RUN: normal operation. Reset is the only way back to INIT.
- Address map:
  - 0x00000-0x0007F: TBL[addr[6:0]], R/W.
  - 0x00100: CTRL, R/W. bit0=lock, bit1=cal_done, bit2=cal_fail; other bits read 0.
  - 0x00101: STATUS, RO. {29'b0, init_done, tbl_locked, cal_done}.
  - 0x00102: SCRATCH, R/W, 32 bits.
  - 0x00103: WRCNT, RO. 16-bit count of accepted writes, saturating at 0xFFFF, zero-extended on read.
  - All other addresses: reads return DEFAULT_RDATA; writes are ignored and raise err_pulse.
- Writes:
  - Take effect on the clock edge where calbus_write=1.
  - TBL writes while tbl_locked=1 are dropped and raise err_pulse.
  - Writes to RO registers are dropped and raise err_pulse.
  - Only accepted writes increment WRCNT.
- Reads:
  - Data is captured at the sampling edge and appears on calbus_rdata exactly RD_LATENCY cycles later.
  - The value is held until the next read result is delivered.
  - Back-to-back reads are fully pipelined, one per cycle.
- Simultaneous read and write in one cycle: the write commits, and the read returns the pre-write value.
- Accesses during INIT:
  - Writes are dropped and raise err_pulse.
  - Reads return 0 at normal latency and raise err_pulse.
- calbus_read and calbus_write both high is legal. Handled as above: the read sees old data.
- calbus_seq_param_tbl is driven directly from table registers. A TBL write is visible on it the cycle after the write edge.
- Reset mid-operation: in-flight read pipeline entries are discarded, so no rdata update follows reset. Table and registers return to reset values and INIT restarts.

Decomposition:
- Package emif_calbus_pkg holds:
  - Address constants: TBL_BASE, TBL_WORDS=128, CTRL_ADDR, STATUS_ADDR, SCRATCH_ADDR, WRCNT_ADDR.
  - CTRL bit indices.
  - FSM state enum {INIT, RUN}.
  - Calbus width constants: ADDR 20, DATA 32, TBL 4096.
- One sub-module: emif_calbus_rd_pipe, a RD_LATENCY-deep valid+data shift register that updates the held calbus_rdata.

Test Plan:
1. Reset with PARAM_INIT word5=0x12345678, then wait 128 cycles. Expect init_done=1 at cycle 128, and calbus_seq_param_tbl[191:160]=0x12345678.
2. In RUN, write 0xA5A5A5A5 to 0x00007, then read 0x00007 with RD_LATENCY=3. Expect the table slice updated one cycle after the write, rdata=0xA5A5A5A5 exactly 3 cycles after the read, and WRCNT=1.
3. Write CTRL=0x1, then write TBL[0]=0xFFFFFFFF. Expect err_pulse for one cycle, TBL[0] unchanged, and WRCNT incremented only for the CTRL write.
4. In one cycle, write SCRATCH=0x55 and read SCRATCH (old value 0). Expect rdata=0. A subsequent read returns 0x55.
5. Read 0x00200. Expect 0xDEADBEEF. Write 0x00101. Expect err_pulse and STATUS unchanged.
6. Issue calbus_write to 0x00000 during INIT, and assert calbus_rst at cycle 1 of an outstanding read with RD_LATENCY=4. Expect the write dropped with err_pulse, no rdata update after reset, and INIT restarting from index 0.
